// File: rtl/vend_pkg.sv
// ============================================================================
// Module  : vend_pkg
// Purpose : Shared definitions for the refund/dispense controller: FSM state
//           encoding, one-hot coin request codes, coin values in 100-won
//           units and the largest balance that may be refunded.
// Ports   : none (package)
// Config  : none
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package vend_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_REQ      = 3'd1,
        ST_WAIT_LOW = 3'd2,
        ST_DONE     = 3'd3,
        ST_ERR      = 3'd4
    } state_t;

    // One-hot hopper request codes
    localparam logic [3:0] COIN_1000 = 4'b1000;
    localparam logic [3:0] COIN_500  = 4'b0100;
    localparam logic [3:0] COIN_200  = 4'b0010;
    localparam logic [3:0] COIN_100  = 4'b0001;

    // Coin values in 100-won units
    localparam logic [3:0] VAL_1000 = 4'd10;
    localparam logic [3:0] VAL_500  = 4'd5;
    localparam logic [3:0] VAL_200  = 4'd2;
    localparam logic [3:0] VAL_100  = 4'd1;

    localparam logic [3:0] MAX_BALANCE = 4'd10;

endpackage

`default_nettype wire

// File: rtl/change_coin_select.sv
// ============================================================================
// Module  : change_coin_select
// Purpose : Combinational greedy coin picker. Returns the largest coin not
//           exceeding the amount still owed, as a one-hot hopper code plus
//           its value in 100-won units. An amount of zero yields no coin.
// Ports   : remaining [3:0] in  - amount still owed (100-won units)
//           coin      [3:0] out - one-hot coin code (0 when nothing owed)
//           value     [3:0] out - value of the selected coin
// Config  : none
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module change_coin_select (
    input  logic [3:0] remaining,
    output logic [3:0] coin,
    output logic [3:0] value
);
    import vend_pkg::*;

    always_comb begin
        coin  = 4'b0000;
        value = 4'd0;
        if (remaining >= VAL_1000) begin
            coin  = COIN_1000;
            value = VAL_1000;
        end else if (remaining >= VAL_500) begin
            coin  = COIN_500;
            value = VAL_500;
        end else if (remaining >= VAL_200) begin
            coin  = COIN_200;
            value = VAL_200;
        end else if (remaining >= VAL_100) begin
            coin  = COIN_100;
            value = VAL_100;
        end
    end

endmodule

`default_nettype wire

// File: rtl/refund_dispense_ctrl.sv
// ============================================================================
// Module  : refund_dispense_ctrl
// Purpose : Refunds a balance (0..10 x 100 won) by requesting coins from a
//           hopper one at a time, greedy largest-first, over a 4-phase
//           req/ack handshake. All outputs are registered.
// Ports   : clk            in   rising-edge clock
//           reset_n        in   asynchronous active-low reset
//           start          in   refund request, honoured only in IDLE
//           balance [3:0]  in   amount to refund, sampled with start
//           coin_ack       in   hopper acknowledge
//           coin_req [3:0] out  one-hot coin request (1000/500/200/100)
//           busy           out  refund in progress
//           done           out  one-cycle completion pulse
//           err            out  sticky error (bad balance or timeout)
//           remaining[3:0] out  amount still to dispense
//           dispensed_cnt  out  saturating coins-dispensed counter
// Config  : REFUND_TIMEOUT_EN - when defined, a coin request left without
//           acknowledge for TIMEOUT_CYCLES cycles aborts to ERR.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module refund_dispense_ctrl #(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int CNT_W          = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [3:0]       balance,
    input  logic             coin_ack,
    output logic [3:0]       coin_req,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [3:0]       remaining,
    output logic [CNT_W-1:0] dispensed_cnt
);
    import vend_pkg::*;

    state_t           r_state,     w_state_nxt;
    logic [3:0]       r_coin_req,  w_coin_req_nxt;
    logic             r_busy,      w_busy_nxt;
    logic             r_done,      w_done_nxt;
    logic             r_err,       w_err_nxt;
    logic [3:0]       r_remaining, w_remaining_nxt;
    logic [CNT_W-1:0] r_cnt,       w_cnt_nxt;

    logic [3:0] w_sel_in;
    logic [3:0] w_sel_coin;
    logic [3:0] w_sel_val;

    // In IDLE the first coin is chosen straight from the incoming balance so
    // the request appears the cycle after start; otherwise the registered
    // remainder drives the picker (already decremented when WAIT_LOW exits).
    assign w_sel_in = (r_state == ST_IDLE) ? balance : r_remaining;

    change_coin_select u_coin_select (
        .remaining (w_sel_in),
        .coin      (w_sel_coin),
        .value     (w_sel_val)
    );

`ifdef REFUND_TIMEOUT_EN
    // Counts REQ cycles without acknowledge; the hit fires on the last
    // permitted cycle so the abort lands after exactly TIMEOUT_CYCLES cycles.
    localparam int TMO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    logic [TMO_W-1:0] r_tmo, w_tmo_nxt;
    logic             w_tmo_hit;

    assign w_tmo_hit = (r_tmo == TMO_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_tmo <= '0;
        else          r_tmo <= w_tmo_nxt;
    end
`else
    logic w_unused_tmo;
    assign w_unused_tmo = (TIMEOUT_CYCLES != 0);
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= ST_IDLE;
            r_coin_req  <= 4'b0000;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
            r_remaining <= 4'd0;
            r_cnt       <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_coin_req  <= w_coin_req_nxt;
            r_busy      <= w_busy_nxt;
            r_done      <= w_done_nxt;
            r_err       <= w_err_nxt;
            r_remaining <= w_remaining_nxt;
            r_cnt       <= w_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_coin_req_nxt  = r_coin_req;
        w_busy_nxt      = r_busy;
        w_done_nxt      = 1'b0;
        w_err_nxt       = r_err;
        w_remaining_nxt = r_remaining;
        w_cnt_nxt       = r_cnt;
`ifdef REFUND_TIMEOUT_EN
        w_tmo_nxt       = r_tmo;
`endif
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    if (balance > MAX_BALANCE) begin
                        w_err_nxt = 1'b1;
                    end else begin
                        w_remaining_nxt = balance;
                        w_busy_nxt      = 1'b1;
                        w_err_nxt       = 1'b0;
                        if (balance == 4'd0) begin
                            w_state_nxt = ST_DONE;
                        end else begin
                            w_state_nxt    = ST_REQ;
                            w_coin_req_nxt = w_sel_coin;
`ifdef REFUND_TIMEOUT_EN
                            w_tmo_nxt      = '0;
`endif
                        end
                    end
                end
            end
            ST_REQ: begin
                if (coin_ack) begin
                    w_coin_req_nxt  = 4'b0000;
                    w_remaining_nxt = r_remaining - w_sel_val;
                    w_cnt_nxt       = (r_cnt == '1) ? r_cnt : r_cnt + CNT_W'(1);
                    w_state_nxt     = ST_WAIT_LOW;
                end
`ifdef REFUND_TIMEOUT_EN
                else if (w_tmo_hit) begin
                    w_coin_req_nxt = 4'b0000;
                    w_err_nxt      = 1'b1;
                    w_busy_nxt     = 1'b0;
                    w_state_nxt    = ST_ERR;
                end else begin
                    w_tmo_nxt = r_tmo + TMO_W'(1);
                end
`endif
            end
            ST_WAIT_LOW: begin
                // Next request only after the hopper releases ack.
                if (!coin_ack) begin
                    if (r_remaining == 4'd0) begin
                        w_state_nxt = ST_DONE;
                    end else begin
                        w_state_nxt    = ST_REQ;
                        w_coin_req_nxt = w_sel_coin;
`ifdef REFUND_TIMEOUT_EN
                        w_tmo_nxt      = '0;
`endif
                    end
                end
            end
            ST_DONE: begin
                w_done_nxt  = 1'b1;
                w_busy_nxt  = 1'b0;
                w_state_nxt = ST_IDLE;
            end
            ST_ERR: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    assign coin_req      = r_coin_req;
    assign busy          = r_busy;
    assign done          = r_done;
    assign err           = r_err;
    assign remaining     = r_remaining;
    assign dispensed_cnt = r_cnt;

endmodule

`default_nettype wire
